// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin, LSB first) with start/done handshake.
// Latency WIDTH+1 cycles from accepted start to done; start ignored while busy; optional ovf via SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             brw_nxt;
    logic [WIDTH-1:0] res_cat;

    // Single full-subtractor cell on the current LSBs.
    assign a_bit   = a_sr[0];
    assign b_bit   = b_sr[0];
    assign d_bit   = a_bit ^ b_bit ^ brw;
    assign brw_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw);
    assign res_cat = {d_bit, res_sr};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= 1'b0;
`endif
        end else if (load) begin
            a_sr <= a_in;
            b_sr <= b_in;
            brw  <= bin;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= res_cat[WIDTH-1:1];
            brw    <= brw_nxt;
            if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                // On the final bit the shift registers hold the operand MSBs at bit 0.
                diff_out   <= res_cat;
                borrow_out <= brw_nxt;
`ifdef SERIAL_SUB_OVF_EN
                ovf        <= (a_bit != b_bit) && (d_bit != a_bit);
`endif
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized + directed scoreboard bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff_out;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .diff_out  (diff_out),
        .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
        logic         o;
    } exp_t;

    exp_t q[$];
    time  done_t[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference: unsigned arithmetic one bit wider; the extra bit is the final borrow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        exp_t     e;
        logic [W:0] r;
        r   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        e.d = r[W-1:0];
        e.b = r[W];
        e.o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_t.push_back($time);
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("diff_out", 32'(diff_out), 32'(e.d));
                check("borrow_out", 32'(borrow_out), 32'(e.b));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(e.o));
`endif
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         input bit push, input bit keep);
        bit ok;
        bit prev;
        a_in  = a;
        b_in  = b;
        bin   = bi;
        start = 1'b1;
        ok    = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            prev = busy;
            @(posedge clk);
            #1;
            if (busy && !prev) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got busy=%0b expected start accepted", busy);
        end else if (push) begin
            q.push_back(model(a, b, bi));
        end
        if (!keep) begin
            start = 1'b0;
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            bin   = 1'($urandom);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int nb;
        int n0;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        bin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff_out), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: basic op with latency check
        issue(8'h05, 8'h03, 1'b0, 1'b1, 1'b0);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) nb++;
            else break;
        end
        check("busy_cycles", 32'(nb), 32'd8);
        check("done_after_busy", 32'(done), 32'd1);
        drain();

        // 2: negative results
        issue(8'h03, 8'h05, 1'b0, 1'b1, 1'b0);
        drain();
        issue(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        drain();

        // 3: start during busy is ignored; result must hold until next op
        n0 = done_t.size();
        issue(8'h40, 8'h11, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        a_in  = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        check("single_done", 32'(done_t.size() - n0), 32'd1);
        repeat (3) @(negedge clk);
        check("result_held", 32'(diff_out), 32'h2F);

        // 4: back-to-back with start held
        n0 = done_t.size();
        issue(8'h10, 8'h01, 1'b0, 1'b1, 1'b1);
        issue(8'h20, 8'h02, 1'b0, 1'b1, 1'b0);
        drain();
        check("b2b_dones", 32'(done_t.size() - n0), 32'd2);
        if (done_t.size() - n0 == 2)
            check("b2b_period", 32'(done_t[n0+1] - done_t[n0]), 32'd90);

        // 5: reset during 4th shift cycle aborts
        issue(8'h77, 8'h12, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        n0 = done_t.size();
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff_out), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_no_done", 32'(done_t.size() - n0), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
        // 6: signed overflow
        issue(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        drain();
        issue(8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
        drain();
`endif

        // Random traffic, occasionally back-to-back
        for (int i = 0; i < 150; i++) begin
            bit keep;
            keep = ($urandom_range(0, 3) == 0) && (i != 149);
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1, keep);
            if (!keep) repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
